pipe_mem_stage: RTL and testbench

//  EX/MEM pipeline register plus MEM-stage data-memory access for the 5-stage pipeline CPU.

---
 rtl/pipe_mem_pkg.sv | 30 +++
 rtl/pipe_mem_align.sv | 62 ++++++
 rtl/pipe_mem_stage.sv | 145 ++++++++++++++
 tb/tb_pipe_mem_stage.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mem_pkg.sv
// Shared definitions for the MEM stage: access-size codes, the bus FSM
// encoding and the EX/MEM slot layout.
package pipe_mem_pkg;

  // Access size codes carried from EXE (esize)
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Data-bus handshake FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } mem_state_t;

  // Contents of the EX/MEM pipeline register
  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] b;
    logic [4:0]  rn;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [1:0]  size;
    logic        sign;
  } m_slot_t;

endpackage

// File: rtl/pipe_mem_align.sv
// Combinational lane logic for the MEM stage: load lane extraction and
// extension, store byte enables and store-data lane replication, plus the
// alignment test for the current access size.
// Sub-word accesses are compiled in only when PIPE_MEM_SUBWORD_EN is defined;
// otherwise every access is treated as a 32-bit word.
module pipe_mem_align
  import pipe_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] sdata,
  output logic        misalign,
  output logic [31:0] load_data,
  output logic [3:0]  be,
  output logic [31:0] wdata
);

`ifdef PIPE_MEM_SUBWORD_EN
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Size-dependent lane selection; anything that is not byte or half is a word
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    misalign  = 1'b0;
    load_data = rdata;
    be        = 4'b1111;
    wdata     = sdata;
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_B: begin
        load_data = {{24{sign & byte_lane[7]}}, byte_lane};
        be        = 4'b0001 << addr_lo;
        wdata     = {4{sdata[7:0]}};
      end
      SZ_H: begin
        misalign  = addr_lo[0];
        load_data = {{16{sign & half_lane[15]}}, half_lane};
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{sdata[15:0]}};
      end
      default: begin
        misalign = (addr_lo != 2'b00);
      end
    endcase
  end
`else
  // Word-only build: size and sign are accepted but have no effect
  logic unused_cfg;
  assign unused_cfg = ^{size, sign};

  assign misalign  = (addr_lo != 2'b00);
  assign load_data = rdata;
  assign be        = 4'b1111;
  assign wdata     = sdata;
`endif

endmodule

// File: rtl/pipe_mem_stage.sv
// EX/MEM pipeline register and MEM-stage data-memory access.
// Captures the EXE results, runs the req/ack data-bus handshake with a wait
// timeout, stalls the front of the pipe while an access is outstanding and
// hands aligned load data to MEM/WB.
// Optional feature macro: PIPE_MEM_SUBWORD_EN (byte/half accesses).
module pipe_mem_stage
  import pipe_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        evalid,
  input  logic [31:0] ealu,
  input  logic [31:0] eb,
  input  logic [4:0]  ern,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic [1:0]  esize,
  input  logic        esign,
  output logic        mvalid,
  output logic [31:0] malu,
  output logic [4:0]  mrn,
  output logic        mwreg,
  output logic        mm2reg,
  output logic [31:0] mmo,
  output logic        mem_stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  m_slot_t     mslot;
  mem_state_t  state, state_next;
  logic [7:0]  wait_cnt, wait_cnt_next;

  logic        mem_access;
  logic        align_mis;
  logic        memop;
  logic        in_err;
  logic [31:0] load_data;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;

  // EX/MEM register: advances whenever the stage is not stalled
  always_ff @(posedge clock) begin
    // NOTE: clocked state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (reset) begin
      mslot <= '0;
    end else if (!mem_stall) begin
      mslot <= '{valid: evalid, alu: ealu, b: eb, rn: ern, wreg: ewreg,
                 m2reg: em2reg, wmem: ewmem, size: esize, sign: esign};
    end
  end

  pipe_mem_align u_align (
    .size      (mslot.size),
    .sign      (mslot.sign),
    .addr_lo   (mslot.alu[1:0]),
    .rdata     (dmem_rdata),
    .sdata     (mslot.b),
    .misalign  (align_mis),
    .load_data (load_data),
    .be        (lane_be),
    .wdata     (lane_wdata)
  );

  // A real memory instruction sits in M; misaligned ones never reach the bus
  assign mem_access = mslot.valid & (mslot.m2reg | mslot.wmem);
  assign misalign   = mem_access & align_mis;
  assign memop      = mem_access & ~align_mis;
  assign in_err     = (state == ST_ERR);

  // Handshake state and wait counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next-state and wait-counter logic for the bus handshake
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (memop && !dmem_ack) begin
          state_next    = ST_WAIT;
          wait_cnt_next = 8'd1;
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          state_next    = ST_IDLE;
          wait_cnt_next = 8'd0;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          state_next    = ST_ERR;
          wait_cnt_next = 8'd0;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      ST_ERR: begin
        state_next    = ST_IDLE;
        wait_cnt_next = 8'd0;
      end
      default: begin
        state_next    = ST_IDLE;
        wait_cnt_next = 8'd0;
      end
    endcase
  end

  // Pipeline-facing outputs; the ERR cycle retires the instruction dead
  assign mvalid    = mslot.valid;
  assign malu      = mslot.alu;
  assign mrn       = mslot.rn;
  assign mm2reg    = mslot.valid & mslot.m2reg;
  assign mwreg     = mslot.valid & mslot.wreg & ~misalign & ~in_err;
  assign mem_stall = memop & ~dmem_ack & ~in_err;
  assign bus_err   = in_err;
  assign mmo       = (dmem_req & mslot.m2reg & dmem_ack) ? load_data : 32'd0;

  // Bus-facing outputs: held stable for the life of the request
  assign dmem_req   = memop & ~in_err;
  assign dmem_we    = dmem_req & mslot.wmem;
  assign dmem_addr  = {mslot.alu[31:2], 2'b00};
  assign dmem_be    = dmem_req ? lane_be : 4'b0000;
  assign dmem_wdata = lane_wdata;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Self-checking bench for pipe_mem_stage: directed vector table, hand-written
// timeout and reset-mid-access sequences, and randomized traffic compared
// against a size/offset arithmetic reference model.
module tb_pipe_mem_stage;

  localparam int unsigned TIMEOUT = 4;
`ifdef PIPE_MEM_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  typedef struct {
    bit          valid;
    bit          ld;
    bit          st;
    bit          wreg;
    logic [1:0]  size;
    bit          sign;
    logic [4:0]  rn;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          ack_delay;   // cycles after the request; -1 = never
  } op_t;

  typedef struct {
    bit          mis;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] mmo;
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t exp;
  } vec_t;

  logic        clock, reset;
  logic        evalid, ewreg, em2reg, ewmem, esign;
  logic [31:0] ealu, eb;
  logic [4:0]  ern;
  logic [1:0]  esize;
  logic        mvalid, mwreg, mm2reg, mem_stall, misalign, bus_err;
  logic [31:0] malu, mmo, dmem_addr, dmem_wdata, dmem_rdata;
  logic [4:0]  mrn;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [3:0]  dmem_be;

  int n_chk = 0;
  int n_err = 0;

  pipe_mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .evalid(evalid), .ealu(ealu), .eb(eb),
    .ern(ern), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .esize(esize),
    .esign(esign), .mvalid(mvalid), .malu(malu), .mrn(mrn), .mwreg(mwreg),
    .mm2reg(mm2reg), .mmo(mmo), .mem_stall(mem_stall), .misalign(misalign),
    .bus_err(bus_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: derived from access width in bytes and byte offset
  function automatic exp_t model(input op_t o);
    exp_t e;
    int nb, off;
    logic [31:0] mask, lane;
    nb = 4;
    if (SUBWORD) nb = (o.size == 2'b00) ? 1 : (o.size == 2'b01) ? 2 : 4;
    off   = int'(o.addr[1:0]);
    e.mis = o.valid && (o.ld || o.st) && ((off % nb) != 0);
    e.be  = 4'(((1 << nb) - 1) << off);
    mask  = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    if (nb == 1)      e.wdata = (o.sdata & 32'hFF) * 32'h0101_0101;
    else if (nb == 2) e.wdata = (o.sdata & 32'hFFFF) * 32'h0001_0001;
    else              e.wdata = o.sdata;
    lane = (o.rdata >> (8 * off)) & mask;
    if (SUBWORD && o.sign && nb < 4 && lane[8 * nb - 1]) lane = lane | ~mask;
    e.mmo = lane;
    return e;
  endfunction

  task automatic drive_e(input op_t o);
    evalid = o.valid; ealu = o.addr; eb = o.sdata; ern = o.rn; ewreg = o.wreg;
    em2reg = o.ld; ewmem = o.st; esize = o.size; esign = o.sign;
  endtask

  task automatic drive_bubble();
    evalid = 1'b0; ewreg = 1'b0; em2reg = 1'b0; ewmem = 1'b0;
  endtask

  // A valid instruction that must not enter M while the stage is stalled
  task automatic drive_garbage();
    evalid = 1'b1; ealu = $urandom; eb = $urandom; ern = 5'($urandom);
    ewreg = 1'b1; em2reg = 1'b1; ewmem = 1'b0; esize = 2'b10; esign = 1'b0;
  endtask

  task automatic run_op(input op_t o, input exp_t e, input string tag);
    bit acc, memop, hit;
    op_t f;
    acc   = o.valid && (o.ld || o.st);
    memop = acc && !e.mis;
    drive_e(o);
    dmem_ack = 1'b0;
    @(posedge clock); #1;
    drive_bubble();
    #1;
    check({tag, ".mvalid"},   32'(mvalid),   32'(o.valid));
    check({tag, ".malu"},     malu,          o.addr);
    check({tag, ".mrn"},      32'(mrn),      32'(o.rn));
    check({tag, ".mm2reg"},   32'(mm2reg),   32'(o.valid && o.ld));
    check({tag, ".misalign"}, 32'(misalign), 32'(acc && e.mis));
    check({tag, ".req"},      32'(dmem_req), 32'(memop));
    if (!memop) begin
      check({tag, ".stall"}, 32'(mem_stall), 32'd0);
      check({tag, ".mwreg"}, 32'(mwreg),     32'(o.valid && o.wreg && !(acc && e.mis)));
      @(posedge clock); #1;
      return;
    end
    check({tag, ".addr"}, dmem_addr,     {o.addr[31:2], 2'b00});
    check({tag, ".we"},   32'(dmem_we),  32'(o.st));
    check({tag, ".be"},   32'(dmem_be),  32'(e.be));
    if (o.st) check({tag, ".wdata"}, dmem_wdata, e.wdata);
    if (o.ack_delay >= 0) begin
      for (int k = 0; k <= o.ack_delay; k++) begin
        hit = (k == o.ack_delay);
        dmem_ack   = hit;
        dmem_rdata = hit ? o.rdata : $urandom;
        if (hit) drive_bubble(); else drive_garbage();
        #1;
        check({tag, ".w_stall"}, 32'(mem_stall), 32'(!hit));
        check({tag, ".w_req"},   32'(dmem_req),  32'd1);
        check({tag, ".w_malu"},  malu,           o.addr);
        check({tag, ".w_addr"},  dmem_addr,      {o.addr[31:2], 2'b00});
        check({tag, ".w_be"},    32'(dmem_be),   32'(e.be));
        check({tag, ".w_mwreg"}, 32'(mwreg),     32'(o.wreg));
        if (o.st) check({tag, ".w_wdata"}, dmem_wdata, e.wdata);
        if (hit)  check({tag, ".mmo"}, mmo, o.ld ? e.mmo : 32'd0);
        @(posedge clock); #1;
      end
      dmem_ack = 1'b0;
    end else begin
      // Request cycle in IDLE, then TIMEOUT stalled cycles in WAIT
      for (int k = 0; k <= int'(TIMEOUT); k++) begin
        dmem_ack = 1'b0;
        drive_garbage();
        #1;
        check({tag, ".t_stall"},  32'(mem_stall), 32'd1);
        check({tag, ".t_req"},    32'(dmem_req),  32'd1);
        check({tag, ".t_buserr"}, 32'(bus_err),   32'd0);
        check({tag, ".t_malu"},   malu,           o.addr);
        @(posedge clock); #1;
      end
      // Abort cycle; the next instruction is presented and must advance
      f = '{valid: 1'b1, ld: 1'b1, st: 1'b0, wreg: 1'b1, size: 2'b10, sign: 1'b0,
            rn: 5'd3, addr: 32'h300, sdata: 32'd0, rdata: 32'h0BAD_F00D, ack_delay: 0};
      drive_e(f);
      #1;
      check({tag, ".err_buserr"}, 32'(bus_err),   32'd1);
      check({tag, ".err_req"},    32'(dmem_req),  32'd0);
      check({tag, ".err_stall"},  32'(mem_stall), 32'd0);
      check({tag, ".err_mwreg"},  32'(mwreg),     32'd0);
      @(posedge clock); #1;
      drive_bubble();
      dmem_ack = 1'b1; dmem_rdata = f.rdata;
      #1;
      check({tag, ".nx_buserr"}, 32'(bus_err),   32'd0);
      check({tag, ".nx_mvalid"}, 32'(mvalid),    32'd1);
      check({tag, ".nx_malu"},   malu,           32'h300);
      check({tag, ".nx_req"},    32'(dmem_req),  32'd1);
      check({tag, ".nx_stall"},  32'(mem_stall), 32'd0);
      check({tag, ".nx_mmo"},    mmo,            32'h0BAD_F00D);
      @(posedge clock); #1;
      dmem_ack = 1'b0;
    end
  endtask

  function automatic vec_t mk(input bit ld, input bit st, input logic [1:0] size,
                              input bit sign, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [31:0] rdata,
                              input int ack, input bit mis, input logic [3:0] be,
                              input logic [31:0] wdata, input logic [31:0] mmo_v);
    vec_t v;
    v.op  = '{valid: 1'b1, ld: ld, st: st, wreg: ld, size: size, sign: sign,
              rn: 5'd7, addr: addr, sdata: sdata, rdata: rdata, ack_delay: ack};
    v.exp = '{mis: mis, be: be, wdata: wdata, mmo: mmo_v};
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    op_t  o;
    exp_t e;
    int   kind;

    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    ealu = 32'd0; eb = 32'd0; ern = 5'd0; esize = 2'b10; esign = 1'b0;
    drive_bubble();

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst.mvalid",   32'(mvalid),    32'd0);
    check("rst.mwreg",    32'(mwreg),     32'd0);
    check("rst.mm2reg",   32'(mm2reg),    32'd0);
    check("rst.stall",    32'(mem_stall), 32'd0);
    check("rst.misalign", 32'(misalign),  32'd0);
    check("rst.buserr",   32'(bus_err),   32'd0);
    check("rst.req",      32'(dmem_req),  32'd0);
    check("rst.malu",     malu,           32'd0);
    check("rst.mmo",      mmo,            32'd0);
    check("rst.mrn",      32'(mrn),       32'd0);
    reset = 1'b0;

    // Directed vectors: ld st size sign addr sdata rdata ack | mis be wdata mmo
    vecs.push_back(mk(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0,
                      0, 4'b1111, 32'h0, 32'hDEAD_BEEF));
    vecs.push_back(mk(1, 0, 2'b10, 0, 32'h106, 32'h0, 32'h1111_1111, 0,
                      1, 4'b1111, 32'h0, 32'h0));
    vecs.push_back(mk(1, 0, 2'b10, 0, 32'h10C, 32'h0, 32'hCAFE_F00D, 4,
                      0, 4'b1111, 32'h0, 32'hCAFE_F00D));
`ifdef PIPE_MEM_SUBWORD_EN
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h103, 32'h0000_005A, 32'h0, 3,
                      0, 4'b1000, 32'h5A5A_5A5A, 32'h0));
    vecs.push_back(mk(1, 0, 2'b01, 1, 32'h202, 32'h0, 32'h8001_1234, 1,
                      0, 4'b1100, 32'h0, 32'hFFFF_8001));
    vecs.push_back(mk(1, 0, 2'b01, 0, 32'h202, 32'h0, 32'h8001_1234, 0,
                      0, 4'b1100, 32'h0, 32'h0000_8001));
    vecs.push_back(mk(1, 0, 2'b00, 1, 32'h101, 32'h0, 32'h0000_8000, 2,
                      0, 4'b0010, 32'h0, 32'hFFFF_FF80));
    vecs.push_back(mk(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'hAB00_0000, 0,
                      0, 4'b1000, 32'h0, 32'h0000_00AB));
    vecs.push_back(mk(0, 1, 2'b01, 0, 32'h201, 32'h0000_BEEF, 32'h0, 0,
                      1, 4'b0110, 32'h0, 32'h0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 32'h202, 32'h1234_BEEF, 32'h0, 2,
                      0, 4'b1100, 32'hBEEF_BEEF, 32'h0));
`else
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h104, 32'h1234_5678, 32'h0, 3,
                      0, 4'b1111, 32'h1234_5678, 32'h0));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h103, 32'h0000_005A, 32'h0, 0,
                      1, 4'b1111, 32'h0, 32'h0));
    vecs.push_back(mk(1, 0, 2'b01, 1, 32'h202, 32'h0, 32'h8001_1234, 0,
                      1, 4'b1111, 32'h0, 32'h0));
    vecs.push_back(mk(1, 0, 2'b00, 1, 32'h108, 32'h0, 32'h0000_00F0, 1,
                      0, 4'b1111, 32'h0, 32'h0000_00F0));
    vecs.push_back(mk(0, 1, 2'b01, 1, 32'h208, 32'hA5A5_8001, 32'h0, 2,
                      0, 4'b1111, 32'hA5A5_8001, 32'h0));
`endif
    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].exp, $sformatf("vec%0d", i));

    // Timeout: no ack ever arrives
    o = '{valid: 1'b1, ld: 1'b1, st: 1'b0, wreg: 1'b1, size: 2'b10, sign: 1'b0,
          rn: 5'd9, addr: 32'h500, sdata: 32'd0, rdata: 32'd0, ack_delay: -1};
    run_op(o, model(o), "timeout");

    // Reset while waiting for ack; a late ack must be ignored
    o = '{valid: 1'b1, ld: 1'b1, st: 1'b0, wreg: 1'b1, size: 2'b10, sign: 1'b0,
          rn: 5'd5, addr: 32'h400, sdata: 32'd0, rdata: 32'd0, ack_delay: 0};
    drive_e(o);
    @(posedge clock); #1;
    drive_bubble();
    #1;
    check("rstw.req0",   32'(dmem_req),  32'd1);
    check("rstw.stall0", 32'(mem_stall), 32'd1);
    @(posedge clock); #1;
    check("rstw.stall1", 32'(mem_stall), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("rstw.req",    32'(dmem_req),  32'd0);
    check("rstw.mvalid", 32'(mvalid),    32'd0);
    check("rstw.stall",  32'(mem_stall), 32'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    #1;
    check("rstw.late_mmo",   mmo,            32'd0);
    check("rstw.late_stall", 32'(mem_stall), 32'd0);
    check("rstw.late_req",   32'(dmem_req),  32'd0);
    check("rstw.late_mwreg", 32'(mwreg),     32'd0);
    @(posedge clock); #1;
    dmem_ack = 1'b0;
    run_op(vecs[0].op, vecs[0].exp, "post_rst");

    // Randomized traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      kind        = int'($urandom_range(0, 2));
      o.valid     = ($urandom_range(0, 7) != 0);
      o.ld        = (kind == 1);
      o.st        = (kind == 2);
      o.wreg      = o.ld ? 1'b1 : ($urandom_range(0, 1) != 0);
      o.size      = 2'($urandom_range(0, 2));
      o.sign      = ($urandom_range(0, 1) != 0);
      o.rn        = 5'($urandom);
      o.addr      = $urandom;
      o.sdata     = $urandom;
      o.rdata     = $urandom;
      o.ack_delay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TIMEOUT));
      e = model(o);
      run_op(o, e, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
